// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU command sequencer: opcodes, command field
// layout, response flag positions and the sequencer FSM states.
package fpu_seq_pkg;

    localparam int unsigned CMD_W    = 53;
    localparam int unsigned OP_LSB   = 50;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned RND_LSB  = 47;
    localparam int unsigned RND_W    = 3;
    localparam int unsigned A1_LSB   = 42;
    localparam int unsigned A2_LSB   = 37;
    localparam int unsigned A3_LSB   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned DATA_W   = 32;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_SQRT  = 3'd3;
    localparam logic [2:0] OP_CMP   = 3'd4;
    localparam logic [2:0] OP_WRITE = 3'd7;

    // rsp_flags = {inv, inexact, div_zero, ov, un, less, eq, great}
    localparam int unsigned FLG_INV      = 7;
    localparam int unsigned FLG_INEXACT  = 6;
    localparam int unsigned FLG_DIV_ZERO = 5;
    localparam int unsigned FLG_OV       = 4;
    localparam int unsigned FLG_UN       = 3;
    localparam int unsigned FLG_LESS     = 2;
    localparam int unsigned FLG_EQ       = 1;
    localparam int unsigned FLG_GREAT    = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_LOAD,
        S_EXEC
    } state_t;

    function automatic logic op_is_arith(input logic [2:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO; wrap-around pointers carry one extra bit so
// full and empty are distinguishable when the indices match.
module fpu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 53
) (
    input  logic             clk,
    input  logic             rstp,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    // a push offered while full is refused even if a pop frees a slot this cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fpu_cmd_seq.sv
// FPU command sequencer: pops queued preload/arithmetic commands, drives the
// FPU control inputs, waits for done (with watchdog) and returns flags.
module fpu_cmd_seq
    import fpu_seq_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned TIMEOUT      = 15,
    parameter logic [4:0]  SCRATCH_ADDR = 5'd31
) (
    input  logic             clk,
    input  logic             rstp,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_flags,
    output logic             rsp_timeout,
    output logic [7:0]       sticky_flags,
    input  logic             flag_clr,
    output logic             busy,
    output logic [31:0]      fpu_inp,
    output logic [4:0]       fpu_addr1,
    output logic [4:0]       fpu_addr2,
    output logic [4:0]       fpu_addr3,
    output logic [2:0]       fpu_opcode,
    output logic [2:0]       fpu_round,
    output logic             fpu_ld,
    output logic             fpu_enable,
    output logic             fpu_act,
    input  logic             fpu_done,
    input  logic             fpu_ov,
    input  logic             fpu_un,
    input  logic             fpu_less,
    input  logic             fpu_eq,
    input  logic             fpu_great,
    input  logic             fpu_inv,
    input  logic             fpu_inexact,
    input  logic             fpu_div_zero
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CMD_W-1:0] cur;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [WD_W-1:0]  wd;
    logic [WD_W-1:0]  wd_nxt;
    logic             capture;
    logic [7:0]       cap_flags;
    logic             cap_timeout;
    logic             slot_free;
    logic [2:0]       head_op;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rstp    (rstp),
        .push    (cmd_valid),
        .pop     (pop),
        .wr_data (cmd_data),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (state != S_IDLE) || !fifo_empty;
    assign slot_free = !rsp_valid || rsp_ready;
    assign head_op   = fifo_head[OP_LSB +: OP_W];

    always_comb begin
        state_nxt   = state;
        wd_nxt      = wd;
        pop         = 1'b0;
        capture     = 1'b0;
        cap_flags   = '0;
        cap_timeout = 1'b0;
        fpu_inp     = '0;
        fpu_addr1   = SCRATCH_ADDR;
        fpu_addr2   = '0;
        fpu_addr3   = '0;
        fpu_opcode  = '0;
        fpu_round   = '0;
        fpu_ld      = 1'b0;
        fpu_enable  = 1'b0;
        fpu_act     = 1'b0;
        case (state)
            S_IDLE: begin
                // preloads never produce a response, so they bypass the slot check
                if (!fifo_empty) begin
                    if (head_op == OP_WRITE) begin
                        pop       = 1'b1;
                        state_nxt = S_WRITE;
                    end else if (slot_free) begin
                        pop = 1'b1;
                        if (op_is_arith(head_op)) begin
                            state_nxt = S_LOAD;
                        end else begin
                            capture            = 1'b1;
                            cap_flags[FLG_INV] = 1'b1;
                        end
                    end
                end
            end
            S_WRITE: begin
                fpu_addr1 = cur[A1_LSB +: ADDR_W];
                fpu_inp   = cur[DATA_LSB +: DATA_W];
                state_nxt = S_IDLE;
            end
            S_LOAD: begin
                fpu_enable = 1'b1;
                fpu_ld     = 1'b1;
                fpu_act    = 1'b1;
                fpu_addr1  = cur[A1_LSB +: ADDR_W];
                fpu_addr2  = cur[A2_LSB +: ADDR_W];
                fpu_addr3  = cur[A3_LSB +: ADDR_W];
                fpu_opcode = cur[OP_LSB +: OP_W];
                fpu_round  = cur[RND_LSB +: RND_W];
                wd_nxt     = '0;
                state_nxt  = S_EXEC;
            end
            S_EXEC: begin
                fpu_enable = 1'b1;
                fpu_act    = 1'b1;
                fpu_addr1  = cur[A1_LSB +: ADDR_W];
                fpu_addr2  = cur[A2_LSB +: ADDR_W];
                fpu_addr3  = cur[A3_LSB +: ADDR_W];
                fpu_opcode = cur[OP_LSB +: OP_W];
                fpu_round  = cur[RND_LSB +: RND_W];
                if (fpu_done) begin
                    capture   = 1'b1;
                    cap_flags = {fpu_inv, fpu_inexact, fpu_div_zero, fpu_ov,
                                 fpu_un, fpu_less, fpu_eq, fpu_great};
                    state_nxt = S_IDLE;
                end else if (wd == WD_LAST) begin
                    capture     = 1'b1;
                    cap_timeout = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    wd_nxt = wd + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            state <= S_IDLE;
            cur   <= '0;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
            if (pop) cur <= fifo_head;
        end
    end

    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            rsp_valid    <= 1'b0;
            rsp_flags    <= '0;
            rsp_timeout  <= 1'b0;
            sticky_flags <= '0;
        end else begin
            if (capture) begin
                rsp_valid   <= 1'b1;
                rsp_flags   <= cap_flags;
                rsp_timeout <= cap_timeout;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // clear first, then OR, so flags captured alongside a clear survive
            sticky_flags <= (flag_clr ? 8'h00 : sticky_flags) | cap_flags;
        end
    end

endmodule
